// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states, owner and
// read/write encodings, and the latency counter width.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } arb_state_e;

    localparam logic OWNER_CPU  = 1'b0;
    localparam logic OWNER_LDR  = 1'b1;

    localparam logic RORW_READ  = 1'b0;
    localparam logic RORW_WRITE = 1'b1;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-requester combinational pick: a lone requester wins; a tie goes to the loader
// under fixed priority, otherwise to whichever requester was not served last.
module arb_rr_pick
    import mem_port_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       ldr_prio,
    output logic       winner
);

    always_comb begin
        winner = OWNER_CPU;
        if (req == 2'b11) begin
            winner = ldr_prio ? OWNER_LDR : ~last;
        end else if (req[1]) begin
            winner = OWNER_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// CPU/loader arbiter and access sequencer for the single-port program/data memory.
// Every output is a flop; each access holds MEM_EN for MEM_LAT cycles, then pulses DONE.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 16,
    parameter int unsigned MEM_LAT  = 2,
    parameter bit          LDR_PRIO = 1'b0
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          CPU_REQ,
    input  logic          CPU_RORW,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [DW-1:0] CPU_WDATA,
    output logic          CPU_DONE,
    input  logic          LDR_REQ,
    input  logic          LDR_RORW,
    input  logic [AW-1:0] LDR_ADDR,
    input  logic [DW-1:0] LDR_WDATA,
    output logic          LDR_DONE,
    output logic [DW-1:0] RDATA,
    output logic          BUSY,
    output logic          OWNER,
    output logic          MEM_EN,
    output logic          RORW,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             rorw_q, rorw_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             mem_en_q, mem_en_d;
    logic             busy_q, busy_d;
    logic             cpu_done_q, cpu_done_d;
    logic             ldr_done_q, ldr_done_d;
    logic             winner;

    arb_rr_pick u_pick (
        .req      ({LDR_REQ, CPU_REQ}),
        .last     (last_q),
        .ldr_prio (LDR_PRIO),
        .winner   (winner)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        owner_d    = owner_q;
        rorw_d     = rorw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mem_en_d   = 1'b0;
        busy_d     = 1'b0;
        cpu_done_d = 1'b0;
        ldr_done_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (CPU_REQ || LDR_REQ) begin
                    owner_d  = winner;
                    rorw_d   = (winner == OWNER_LDR) ? LDR_RORW  : CPU_RORW;
                    addr_d   = (winner == OWNER_LDR) ? LDR_ADDR  : CPU_ADDR;
                    wdata_d  = (winner == OWNER_LDR) ? LDR_WDATA : CPU_WDATA;
                    cnt_d    = CNT_INIT;
                    mem_en_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    if (rorw_q == RORW_READ) begin
                        rdata_d = MEM_RDATA;
                    end
                    cpu_done_d = (owner_q == OWNER_CPU);
                    ldr_done_d = (owner_q == OWNER_LDR);
                    state_d    = StDone;
                end else begin
                    mem_en_d = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pointer resets to "loader served last" so the CPU takes the first tie.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_q     <= OWNER_LDR;
            owner_q    <= OWNER_CPU;
            rorw_q     <= RORW_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mem_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            cpu_done_q <= 1'b0;
            ldr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            rorw_q     <= rorw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            mem_en_q   <= mem_en_d;
            busy_q     <= busy_d;
            cpu_done_q <= cpu_done_d;
            ldr_done_q <= ldr_done_d;
        end
    end

    assign CPU_DONE  = cpu_done_q;
    assign LDR_DONE  = ldr_done_q;
    assign RDATA     = rdata_q;
    assign BUSY      = busy_q;
    assign OWNER     = owner_q;
    assign MEM_EN    = mem_en_q;
    assign RORW      = rorw_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: four instances (LAT2/RR, LAT2/LDR-prio, LAT4/RR, LAT1/RR) share
// the request inputs and have separate resets.
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic [3:0]  rst_n = 4'hF;
    logic        cpu_req, cpu_rorw, ldr_req, ldr_rorw;
    logic [7:0]  cpu_addr, ldr_addr;
    logic [15:0] cpu_wdata, ldr_wdata, mem_rdata;

    logic        cpu_done [4];
    logic        ldr_done [4];
    logic        busy     [4];
    logic        owner    [4];
    logic        mem_en   [4];
    logic        rorw     [4];
    logic [7:0]  mem_addr [4];
    logic [15:0] mem_wdata[4];
    logic [15:0] rdata    [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_port_arb #(
            .AW       (8),
            .DW       (16),
            .MEM_LAT  ((g == 2) ? 4 : (g == 3) ? 1 : 2),
            .LDR_PRIO (g == 1)
        ) u_dut (
            .CLK       (clk),
            .RESET_N   (rst_n[g]),
            .CPU_REQ   (cpu_req),
            .CPU_RORW  (cpu_rorw),
            .CPU_ADDR  (cpu_addr),
            .CPU_WDATA (cpu_wdata),
            .CPU_DONE  (cpu_done[g]),
            .LDR_REQ   (ldr_req),
            .LDR_RORW  (ldr_rorw),
            .LDR_ADDR  (ldr_addr),
            .LDR_WDATA (ldr_wdata),
            .LDR_DONE  (ldr_done[g]),
            .RDATA     (rdata[g]),
            .BUSY      (busy[g]),
            .OWNER     (owner[g]),
            .MEM_EN    (mem_en[g]),
            .RORW      (rorw[g]),
            .MEM_ADDR  (mem_addr[g]),
            .MEM_WDATA (mem_wdata[g]),
            .MEM_RDATA (mem_rdata)
        );
    end

    typedef struct {
        logic        creq, crw;
        logic [7:0]  caddr;
        logic [15:0] cwd;
        logic        lreq, lrw;
        logic [7:0]  laddr;
        logic [15:0] lwd;
        logic [15:0] mrd;
        logic        en, rw;
        logic [7:0]  addr;
        logic [15:0] wd;
        logic        cd, ld;
        logic [15:0] rd;
        logic        bsy, own;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t v(
        input logic creq, crw, input logic [7:0] caddr, input logic [15:0] cwd,
        input logic lreq, lrw, input logic [7:0] laddr, input logic [15:0] lwd,
        input logic [15:0] mrd,
        input logic en, rw, input logic [7:0] addr, input logic [15:0] wd,
        input logic cd, ld, input logic [15:0] rd, input logic bsy, own);
        vec_t r;
        r.creq = creq; r.crw = crw; r.caddr = caddr; r.cwd = cwd;
        r.lreq = lreq; r.lrw = lrw; r.laddr = laddr; r.lwd = lwd;
        r.mrd = mrd;
        r.en = en; r.rw = rw; r.addr = addr; r.wd = wd;
        r.cd = cd; r.ld = ld; r.rd = rd; r.bsy = bsy; r.own = own;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset(input logic [3:0] mask);
        @(negedge clk);
        rst_n = rst_n & ~mask;
        #1;
        rst_n = rst_n | mask;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_rorw = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_rorw = 0; ldr_addr = '0; ldr_wdata = '0;
    endtask

    int          n0, n1, lat, seen;
    logic [3:0]  s0, s1;

    initial begin
        idle_inputs();
        mem_rdata = '0;

        vecs[0]  = v(1,0,8'h05,16'h0000, 0,0,8'h00,16'h0000, 16'h1234,
                     1,0,8'h05,16'h0000, 0,0,16'h0000, 1,0);
        vecs[1]  = vecs[0];
        vecs[2]  = v(1,0,8'h05,16'h0000, 0,0,8'h00,16'h0000, 16'h1234,
                     0,0,8'h05,16'h0000, 1,0,16'h1234, 1,0);
        vecs[3]  = v(0,0,8'h05,16'h0000, 0,0,8'h00,16'h0000, 16'h1234,
                     0,0,8'h05,16'h0000, 0,0,16'h1234, 0,0);
        vecs[4]  = v(0,0,8'h00,16'h0000, 1,1,8'h10,16'hBEEF, 16'h5555,
                     1,1,8'h10,16'hBEEF, 0,0,16'h1234, 1,1);
        vecs[5]  = vecs[4];
        vecs[6]  = v(0,0,8'h00,16'h0000, 1,1,8'h10,16'hBEEF, 16'h5555,
                     0,1,8'h10,16'hBEEF, 0,1,16'h1234, 1,1);
        vecs[7]  = v(0,0,8'h00,16'h0000, 0,1,8'h10,16'hBEEF, 16'h5555,
                     0,1,8'h10,16'hBEEF, 0,0,16'h1234, 0,1);
        vecs[8]  = v(1,1,8'h22,16'h0077, 0,0,8'h33,16'h0000, 16'h5555,
                     1,1,8'h22,16'h0077, 0,0,16'h1234, 1,0);
        vecs[9]  = v(1,1,8'h22,16'h0077, 1,0,8'h33,16'h0000, 16'h5555,
                     1,1,8'h22,16'h0077, 0,0,16'h1234, 1,0);
        vecs[10] = v(1,1,8'h22,16'h0077, 1,0,8'h33,16'h0000, 16'h5555,
                     0,1,8'h22,16'h0077, 1,0,16'h1234, 1,0);
        vecs[11] = v(0,1,8'h22,16'h0077, 1,0,8'h33,16'h0000, 16'hABCD,
                     0,1,8'h22,16'h0077, 0,0,16'h1234, 0,0);
        vecs[12] = v(0,1,8'h22,16'h0077, 1,0,8'h33,16'h0000, 16'hABCD,
                     1,0,8'h33,16'h0000, 0,0,16'h1234, 1,1);
        vecs[13] = vecs[12];
        vecs[14] = v(0,1,8'h22,16'h0077, 1,0,8'h33,16'h0000, 16'hABCD,
                     0,0,8'h33,16'h0000, 0,1,16'hABCD, 1,1);
        vecs[15] = v(0,1,8'h22,16'h0077, 0,0,8'h33,16'h0000, 16'hABCD,
                     0,0,8'h33,16'h0000, 0,0,16'hABCD, 0,1);

        // Reset values
        #2 rst_n = 4'h0;
        @(negedge clk);
        #1;
        check("rst mem_en",   mem_en[0],    0);
        check("rst rorw",     rorw[0],      0);
        check("rst addr",     mem_addr[0],  0);
        check("rst wdata",    mem_wdata[0], 0);
        check("rst cpu_done", cpu_done[0],  0);
        check("rst ldr_done", ldr_done[0],  0);
        check("rst rdata",    rdata[0],     0);
        check("rst busy",     busy[0],      0);
        check("rst owner",    owner[0],     0);
        rst_n = 4'hF;

        // Cycle-by-cycle vectors against the LAT=2 round-robin instance
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cpu_req = vecs[i].creq; cpu_rorw = vecs[i].crw;
            cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
            ldr_req = vecs[i].lreq; ldr_rorw = vecs[i].lrw;
            ldr_addr = vecs[i].laddr; ldr_wdata = vecs[i].lwd;
            mem_rdata = vecs[i].mrd;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d mem_en", i),   mem_en[0],    vecs[i].en);
            check($sformatf("vec%0d rorw", i),     rorw[0],      vecs[i].rw);
            check($sformatf("vec%0d addr", i),     mem_addr[0],  vecs[i].addr);
            check($sformatf("vec%0d wdata", i),    mem_wdata[0], vecs[i].wd);
            check($sformatf("vec%0d cpu_done", i), cpu_done[0],  vecs[i].cd);
            check($sformatf("vec%0d ldr_done", i), ldr_done[0],  vecs[i].ld);
            check($sformatf("vec%0d rdata", i),    rdata[0],     vecs[i].rd);
            check($sformatf("vec%0d busy", i),     busy[0],      vecs[i].bsy);
            check($sformatf("vec%0d owner", i),    owner[0],     vecs[i].own);
        end

        // Continuous tie: round-robin alternates from CPU, loader priority always loader
        @(negedge clk);
        idle_inputs();
        pulse_reset(4'b0011);
        @(negedge clk);
        cpu_req = 1; cpu_addr = 8'h01;
        ldr_req = 1; ldr_addr = 8'h02;
        n0 = 0; n1 = 0; s0 = '0; s1 = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (cpu_done[0] || ldr_done[0]) begin
                if (n0 < 4) s0[n0] = ldr_done[0];
                n0++;
            end
            if (cpu_done[1] || ldr_done[1]) begin
                if (n1 < 4) s1[n1] = ldr_done[1];
                n1++;
            end
        end
        check("rr grants",   n0, 4);
        check("rr order",    s0, 4'b1010);
        check("prio grants", n1, 4);
        check("prio order",  s1, 4'b1111);
        @(negedge clk);
        ldr_req = 0;
        @(posedge clk);
        #1;
        check("prio cpu when ldr idle en",    mem_en[1], 1);
        check("prio cpu when ldr idle owner", owner[1],  0);
        @(negedge clk);
        idle_inputs();
        repeat (5) @(negedge clk);

        // Async reset in the second ACCESS cycle of the LAT=4 instance
        pulse_reset(4'b0100);
        @(negedge clk);
        cpu_req = 1; cpu_rorw = 0; cpu_addr = 8'h44; mem_rdata = 16'h9999;
        @(posedge clk);
        #1;
        check("lat4 grant mem_en", mem_en[2], 1);
        @(posedge clk);
        #3;
        rst_n[2] = 1'b0;
        #1;
        check("async rst mem_en", mem_en[2],   0);
        check("async rst busy",   busy[2],     0);
        check("async rst addr",   mem_addr[2], 0);
        cpu_req = 0;
        repeat (2) @(negedge clk);
        rst_n[2] = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (cpu_done[2]) seen++;
        end
        check("no done after rst", seen, 0);
        @(negedge clk);
        cpu_req = 1; cpu_addr = 8'h45; mem_rdata = 16'h7777;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cpu_done[2]) break;
        end
        check("lat4 done latency", lat, 5);
        check("lat4 rdata", rdata[2], 16'h7777);
        @(negedge clk);
        cpu_req = 0;
        repeat (3) @(negedge clk);

        // LAT=1 with the request dropped during ACCESS
        pulse_reset(4'b1000);
        @(negedge clk);
        cpu_req = 1; cpu_rorw = 0; cpu_addr = 8'h66; mem_rdata = 16'h4321;
        @(posedge clk);
        #1;
        lat = 1;
        check("lat1 grant mem_en", mem_en[3], 1);
        @(negedge clk);
        cpu_req = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cpu_done[3]) break;
        end
        check("lat1 done latency", lat, 2);
        check("lat1 rdata", rdata[3], 16'h4321);
        check("lat1 mem_en in done", mem_en[3], 0);
        @(posedge clk);
        #1;
        check("lat1 done one cycle", cpu_done[3], 0);
        check("lat1 idle busy", busy[3], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
